// File: rtl/gray_to_bin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_to_bin_pkg
// Description : Shared constants and elaboration helpers for the Gray-to-
//               binary converter and its suffix-XOR scan.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_to_bin_pkg;

    // Default converted word width.
    localparam int c_DEFAULT_WIDTH = 5;

    // Number of doubling stages a log-depth suffix scan needs to cover w bits.
    // Returns ceil(log2(w)), and 0 for a 1-bit word.
    function automatic int scan_levels(input int w);
        int l;
        l = 0;
        while ((1 << l) < w) begin
            l = l + 1;
        end
        return l;
    endfunction

endpackage : gray_to_bin_pkg
`default_nettype wire

// File: rtl/gray_to_bin_xor_prefix_scan.sv
`default_nettype none
// ============================================================================
// Module      : xor_prefix_scan
// Description : Suffix XOR-reduction of a vector: o_suffix[i] is the XOR of
//               i_vec[width_p-1:i]. Built as a log-depth doubling scan so the
//               depth grows with log2(width_p) rather than width_p.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_prefix_scan
    import gray_to_bin_pkg::*;
#(
    parameter int width_p = c_DEFAULT_WIDTH
) (
    input  logic [width_p-1:0] i_vec,
    output logic [width_p-1:0] o_suffix
);

    localparam int c_LEVELS = scan_levels(width_p);

    logic [width_p-1:0] w_acc;

    // Doubling scan: after stage l each bit holds the XOR of the 2^(l+1)
    // bits at and above it. The logical right shift feeds zeros in at the
    // top, so bits near the MSB simply stop accumulating once they reach it.
    always_comb begin
        w_acc = i_vec;
        for (int l = 0; l < c_LEVELS; l++) begin
            w_acc = w_acc ^ (w_acc >> (1 << l));
        end
    end

    assign o_suffix = w_acc;

endmodule : xor_prefix_scan
`default_nettype wire

// File: rtl/gray_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : gray_to_bin
// Description : Reflected Gray code to binary converter. bin_o is purely
//               combinational; bin_r_o is the same value registered, with a
//               synchronous active-high reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_to_bin
    import gray_to_bin_pkg::*;
#(
    parameter int width_p = c_DEFAULT_WIDTH
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] bin_o,
    output logic [width_p-1:0] bin_r_o
);

    logic [width_p-1:0] w_bin;
    logic [width_p-1:0] r_bin;

    // Binary bit i is the XOR of all Gray bits from the MSB down to i, which
    // is exactly the suffix XOR-reduction. An unknown Gray bit therefore only
    // pollutes its own and lower binary bits.
    xor_prefix_scan #(
        .width_p (width_p)
    ) u_scan (
        .i_vec    (gray_i),
        .o_suffix (w_bin)
    );

    // Pipelined copy for consumers that want a registered value.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_bin <= '0;
        end else begin
            r_bin <= w_bin;
        end
    end

    assign bin_o   = w_bin;
    assign bin_r_o = r_bin;

endmodule : gray_to_bin
`default_nettype wire

// File: tb/tb_gray_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_to_bin
// Description : Scoreboard bench for gray_to_bin at widths 1, 2, 5, 8, 32.
//               Stimulus pushes expected results into a queue; a monitor on
//               the falling edge pops and compares both outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_to_bin;

    typedef struct {
        logic [63:0] e5;
        logic [63:0] e1;
        logic [63:0] e2;
        logic [63:0] e8;
        logic [63:0] e32;
        logic        rst;
        string       tag;
    } item_t;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic [4:0]  r_g5;
    logic [0:0]  r_g1;
    logic [1:0]  r_g2;
    logic [7:0]  r_g8;
    logic [31:0] r_g32;

    logic [4:0]  w_b5,  w_br5;
    logic [0:0]  w_b1,  w_br1;
    logic [1:0]  w_b2,  w_br2;
    logic [7:0]  w_b8,  w_br8;
    logic [31:0] w_b32, w_br32;

    item_t       qc[$];
    item_t       qr[$];
    int          r_cnt    = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 r_clk = ~r_clk;

    gray_to_bin #(.width_p(5)) u_dut5 (
        .clk_i(r_clk), .reset_i(r_rst), .gray_i(r_g5), .bin_o(w_b5), .bin_r_o(w_br5));
    gray_to_bin #(.width_p(1)) u_dut1 (
        .clk_i(r_clk), .reset_i(r_rst), .gray_i(r_g1), .bin_o(w_b1), .bin_r_o(w_br1));
    gray_to_bin #(.width_p(2)) u_dut2 (
        .clk_i(r_clk), .reset_i(r_rst), .gray_i(r_g2), .bin_o(w_b2), .bin_r_o(w_br2));
    gray_to_bin #(.width_p(8)) u_dut8 (
        .clk_i(r_clk), .reset_i(r_rst), .gray_i(r_g8), .bin_o(w_b8), .bin_r_o(w_br8));
    gray_to_bin #(.width_p(32)) u_dut32 (
        .clk_i(r_clk), .reset_i(r_rst), .gray_i(r_g32), .bin_o(w_b32), .bin_r_o(w_br32));

    // Reference: binary = g ^ (g>>1) ^ (g>>2) ^ ... over the word width.
    function automatic logic [63:0] ref_bin(input logic [63:0] g, input int w);
        logic [63:0] m;
        logic [63:0] r;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        g = g & m;
        r = '0;
        for (int s = 0; s < w; s++) begin
            r = r ^ (g >> s);
        end
        return r & m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One stimulus cycle: drive all widths just after the edge, record expectations.
    task automatic step(input logic [4:0] g5, input logic [4:0] e5,
                        input logic rst, input string tag);
        item_t it;
        @(posedge r_clk);
        #1;
        r_rst = rst;
        r_g5  = g5;
        r_g1  = r_cnt[0:0];
        r_g2  = r_cnt[1:0];
        r_g8  = r_cnt[7:0];
        r_g32 = $urandom();
        it.e5  = 64'(e5);
        it.e1  = ref_bin(64'(r_g1), 1);
        it.e2  = ref_bin(64'(r_g2), 2);
        it.e8  = ref_bin(64'(r_g8), 8);
        it.e32 = ref_bin(64'(r_g32), 32);
        it.rst = rst;
        it.tag = tag;
        qc.push_back(it);
        r_cnt++;
    endtask

    // Monitor: combinational results of this cycle, registered results of the last.
    always @(negedge r_clk) begin
        item_t it;
        if (qc.size() > 0) begin
            it = qc.pop_front();
            chk({it.tag, " bin_o w5"},  64'(w_b5),  it.e5);
            chk({it.tag, " bin_o w1"},  64'(w_b1),  it.e1);
            chk({it.tag, " bin_o w2"},  64'(w_b2),  it.e2);
            chk({it.tag, " bin_o w8"},  64'(w_b8),  it.e8);
            chk({it.tag, " bin_o w32"}, 64'(w_b32), it.e32);
            qr.push_back(it);
        end
        if (qr.size() >= 2) begin
            it = qr.pop_front();
            chk({it.tag, " bin_r_o w5"},  64'(w_br5),  it.rst ? 64'd0 : it.e5);
            chk({it.tag, " bin_r_o w1"},  64'(w_br1),  it.rst ? 64'd0 : it.e1);
            chk({it.tag, " bin_r_o w2"},  64'(w_br2),  it.rst ? 64'd0 : it.e2);
            chk({it.tag, " bin_r_o w8"},  64'(w_br8),  it.rst ? 64'd0 : it.e8);
            chk({it.tag, " bin_r_o w32"}, 64'(w_br32), it.rst ? 64'd0 : it.e32);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [4:0] sp_g [7];
        logic [4:0] sp_e [7];
        logic [4:0] g;
        sp_g = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b10000, 5'b11111, 5'b11000};
        sp_e = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b11111, 5'b10101, 5'b10000};
        r_rst = 1'b1;
        r_g5  = '0;
        r_g1  = '0;
        r_g2  = '0;
        r_g8  = '0;
        r_g32 = '0;

        // Reset held with all-ones Gray input, then released.
        for (int i = 0; i < 3; i++) step(5'b11111, 5'b10101, 1'b1, "rst_hold");
        step(5'b11111, 5'b10101, 1'b0, "rst_release");

        // Spot values, ending with 11000 -> 10000 for the registered path.
        for (int i = 0; i < 7; i++) step(sp_g[i], sp_e[i], 1'b0, "spot");

        // Exhaustive width-5 sweep.
        for (int i = 0; i < 32; i++) step(5'(i), ref_bin(64'(i), 5), 1'b0, "exh5");

        // Round trip: encode each binary value to Gray, expect it back.
        for (int b = 0; b < 32; b++) step(5'(b ^ (b >> 1)), 5'(b), 1'b0, "roundtrip");

        // Random traffic with a two-cycle reset pulse mid-stream.
        for (int i = 0; i < 1000; i++) begin
            g = 5'($urandom_range(0, 31));
            step(g, ref_bin(64'(g), 5), (i == 400) || (i == 401), "random");
        end

        // Final cycle lets the last registered value be compared.
        step(5'b00000, 5'b00000, 1'b0, "drain");
        @(negedge r_clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_gray_to_bin
`default_nettype wire
